cdc_result_collector: RTL and testbench
=======================================

Name: cdc_result_collector

Overview:
- Sits directly downstream of the clock-domain-crossing compute stage, in the clk_2 domain.
- Consumes that stage's 1-cycle out_valid/out[7:0] result pulses and buffers them in a small FIFO.
- Reduces each group of GROUP results to sum/max/min.
- Presents each group record to the testbench/sink under a valid/ready handshake, dropping and counting inputs when the buffer overflows.

Parameters:
- DEPTH, 4, FIFO entries (power of 2, 2..16).
- GROUP, 4, results per output record (2..16).

Ports:
- clk  input  1  single clock (clk_2 domain).
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  1-cycle result strobe from the upstream stage.
- in  input  8  result value, sampled when in_valid=1.
- out_ready  input  1  sink accepts the record when out_valid=1 and out_ready=1.
- out_valid  output  1  record valid, held until accepted.
- out_sum  output  12  sum of GROUP results, zero-extended.
- out_max  output  8  maximum of the group.
- out_min  output  8  minimum of the group.
- full  output  1  FIFO holds DEPTH entries.
- drop  output  1  1-cycle pulse when an input is discarded.
- drop_cnt  output  8  count of discarded inputs, saturates at 255.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, FIFO empty, FSM in ACC, group counter 0, accumulators cleared (sum=0, max=0, min=255).
- Reset mid-operation discards all buffered data and any partial group.

FIFO:
- Push when in_valid=1 and (not full, or a pop occurs in the same cycle).
- in_valid=1 with full=1 and no pop in that cycle: data is discarded, drop=1 that cycle, drop_cnt+1 (saturating).
- Pointers wrap modulo DEPTH.
- full and empty are registered counts, updated on the clock edge after the push/pop.
- A pushed word can be popped no earlier than the next cycle.

FSM states:
- ACC:
  - Pop one entry per cycle while the FIFO is non-empty.
  - Each pop updates sum+=v, max=max(max,v), min=min(min,v) and increments the group counter.
  - On the pop that makes the counter equal GROUP, capture the final values into the output registers, clear the accumulators and counter, and go to HOLD.
  - out_valid=1 from the next cycle.
- HOLD:
  - out_valid=1; out_sum, out_max and out_min stay stable.
  - No pops. The FIFO still accepts pushes until full.
  - When out_valid & out_ready: go to ACC, out_valid=0 next cycle, outputs hold their last values.
- out_ready is ignored in ACC.

Latency and throughput:
- Minimum latency from the GROUP-th in_valid to out_valid is 2 cycles (push, pop/capture).
- Peak throughput is one record per GROUP+1 cycles when out_ready is held at 1.

Arithmetic:
- Unsigned.
- Sum is 12 bits; it cannot overflow because 16*255 < 4096.
- out_min of a group of all-255 values is 255.

Boundary cases:
- in_valid every cycle with out_ready=0: FIFO fills, then drops begin.
- Simultaneous push and pop on a full FIFO: both succeed, full stays 1, no drop.
- Simultaneous push and pop on an empty FIFO: not possible (pop requires non-empty), so the push is accepted.
- A partial group persists indefinitely while awaiting inputs.

Test Plan:
- Reset, then inputs 10,20,30,40 at spaced cycles with out_ready=1 -> out_valid for 1 cycle, 2 cycles after the 40 input; sum=100, max=40, min=10; drop_cnt=0.
- Inputs 255,255,255,255 back-to-back -> sum=1020, max=255, min=255; then 0,1,2,3 -> sum=6, max=3, min=0 (accumulators cleared between groups).
- out_ready=0, 12 back-to-back inputs 1..12 -> first record (1..4) held stable in HOLD; FIFO gets 5..8, full=1; inputs 9..12 each pulse drop; drop_cnt=4. Then raise out_ready -> records sum=10 then sum=26; no record for 9..12.
- Full FIFO in HOLD with out_ready=1 and in_valid on the acceptance cycle -> still dropped (no pop in HOLD), drop_cnt increments. Next ACC cycle with push+pop while full -> push accepted, no drop.
- 300 drops -> drop_cnt saturates at 255.
- rst_n asserted asynchronously mid-group (after 2 of 4 inputs) and while out_valid=1 -> outputs 0 immediately. After release, 4 new inputs 5,6,7,8 -> sum=26, max=8, min=5 (no stale data).

Source files
------------

// File: rtl/cdc_result_collector.sv
// cdc_result_collector
// Collects 1-cycle result strobes from the upstream clk_2 compute stage in a
// small FIFO. Each GROUP results are reduced to sum/max/min, and the record is
// offered to the sink under valid/ready. Inputs that arrive while the buffer
// cannot take them are dropped and counted.
module cdc_result_collector #(
   parameter int unsigned DEPTH = 4,   // FIFO entries, power of 2, 2..16
   parameter int unsigned GROUP = 4    // results per record, 2..16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [11:0] out_sum,
   output logic [7:0]  out_max,
   output logic [7:0]  out_min,
   output logic        full,
   output logic        drop,
   output logic [7:0]  drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned GW = $clog2(GROUP + 1);

   localparam logic [0:0] ST_ACC  = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   // ---------------------------------------------------------------------
   // FIFO storage and bookkeeping
   // ---------------------------------------------------------------------
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          full_q, full_d;
   logic          empty_q, empty_d;

   // ---------------------------------------------------------------------
   // Reduction FSM state, accumulators and output record
   // ---------------------------------------------------------------------
   logic [0:0]    state_q, state_d;
   logic [GW-1:0] grp_cnt_q, grp_cnt_d;
   logic [11:0]   sum_acc_q, sum_acc_d;
   logic [7:0]    max_acc_q, max_acc_d;
   logic [7:0]    min_acc_q, min_acc_d;

   logic          out_valid_q, out_valid_d;
   logic [11:0]   out_sum_q, out_sum_d;
   logic [7:0]    out_max_q, out_max_d;
   logic [7:0]    out_min_q, out_min_d;

   logic [7:0]    drop_cnt_q, drop_cnt_d;

   // ---------------------------------------------------------------------
   // Handshake-level control
   // ---------------------------------------------------------------------
   logic          pop;
   logic          push;
   logic          drop_w;
   logic [7:0]    pop_data;
   logic [11:0]   new_sum;
   logic [7:0]    new_max;
   logic [7:0]    new_min;

   assign pop_data = mem_q[rd_ptr_q];

   // Pop only while accumulating; a full FIFO can still take a push when it pops.
   always_comb begin
      pop    = (state_q == ST_ACC) && !empty_q;
      push   = in_valid && (!full_q || pop);
      drop_w = in_valid && full_q && !pop;
   end

   // Pointer and occupancy next-state; full/empty are re-derived from the count.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      full_d  = (count_d == CW'(DEPTH));
      empty_d = (count_d == '0);
   end

   // FIFO data array; contents need no reset since occupancy guards every read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in;
      end
   end

   // FIFO pointer and flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
      end
   end

   // Running reduction values including the word being popped this cycle.
   always_comb begin
      new_sum = sum_acc_q + {4'b0000, pop_data};
      new_max = (pop_data > max_acc_q) ? pop_data : max_acc_q;
      new_min = (pop_data < min_acc_q) ? pop_data : min_acc_q;
   end

   // Reduction FSM: accumulate in ACC, present the finished record in HOLD.
   always_comb begin
      state_d     = state_q;
      grp_cnt_d   = grp_cnt_q;
      sum_acc_d   = sum_acc_q;
      max_acc_d   = max_acc_q;
      min_acc_d   = min_acc_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_max_d   = out_max_q;
      out_min_d   = out_min_q;
      case (state_q)
         ST_ACC: begin
            if (pop) begin
               if (grp_cnt_q == GW'(GROUP - 1)) begin
                  out_sum_d   = new_sum;
                  out_max_d   = new_max;
                  out_min_d   = new_min;
                  out_valid_d = 1'b1;
                  sum_acc_d   = '0;
                  max_acc_d   = '0;
                  min_acc_d   = '1;
                  grp_cnt_d   = '0;
                  state_d     = ST_HOLD;
               end else begin
                  sum_acc_d   = new_sum;
                  max_acc_d   = new_max;
                  min_acc_d   = new_min;
                  grp_cnt_d   = grp_cnt_q + 1'b1;
               end
            end
         end
         ST_HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_ACC;
            end
         end
         default: begin
            state_d = ST_ACC;
         end
      endcase
   end

   // FSM, accumulator and output-record registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_ACC;
         grp_cnt_q   <= '0;
         sum_acc_q   <= '0;
         max_acc_q   <= '0;
         min_acc_q   <= '1;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_max_q   <= '0;
         out_min_q   <= '0;
      end else begin
         state_q     <= state_d;
         grp_cnt_q   <= grp_cnt_d;
         sum_acc_q   <= sum_acc_d;
         max_acc_q   <= max_acc_d;
         min_acc_q   <= min_acc_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_max_q   <= out_max_d;
         out_min_q   <= out_min_d;
      end
   end

   // Saturating count of discarded inputs.
   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop_w && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 1'b1;
      end
   end

   // Drop counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_max   = out_max_q;
   assign out_min   = out_min_q;
   assign full      = full_q;
   assign drop      = drop_w;
   assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_cdc_result_collector.sv
// Self-checking bench for cdc_result_collector: a queue-based model of the
// buffer and group reduction is compared with the DUT every cycle, and a few
// directed scenarios pin literal record values, latency, drops and reset.
module tb_cdc_result_collector;

   localparam int DEPTH = 4;
   localparam int GROUP = 4;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_d;
   logic        out_ready;
   logic        o_valid;
   logic [11:0] o_sum;
   logic [7:0]  o_max;
   logic [7:0]  o_min;
   logic        o_full;
   logic        o_drop;
   logic [7:0]  o_drop_cnt;

   int checks = 0;
   int passes = 0;

   cdc_result_collector #(.DEPTH(DEPTH), .GROUP(GROUP)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in       (in_d),
      .out_ready(out_ready),
      .out_valid(o_valid),
      .out_sum  (o_sum),
      .out_max  (o_max),
      .out_min  (o_min),
      .full     (o_full),
      .drop     (o_drop),
      .drop_cnt (o_drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ------------------------------------------------------------------
   // Behavioural model: FIFO as a queue, pending group as a list,
   // record values computed over the whole group at completion.
   // ------------------------------------------------------------------
   int unsigned m_fifo[$];
   int unsigned m_grp[$];
   bit          m_hold;
   int unsigned m_sum, m_max, m_min, m_cnt;

   initial begin
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_fifo.delete();
            m_grp.delete();
            m_hold = 1'b0;
            m_sum = 0; m_max = 0; m_min = 0; m_cnt = 0;
         end else begin
            bit can_pop, take;
            can_pop = !m_hold && (m_fifo.size() > 0);
            take    = in_valid && ((m_fifo.size() < DEPTH) || can_pop);
            if (m_hold) begin
               if (out_ready) m_hold = 1'b0;
            end else if (can_pop) begin
               m_grp.push_back(m_fifo.pop_front());
               if (m_grp.size() == GROUP) begin
                  m_sum = 0; m_max = 0; m_min = 255;
                  foreach (m_grp[k]) begin
                     m_sum += m_grp[k];
                     if (m_grp[k] > m_max) m_max = m_grp[k];
                     if (m_grp[k] < m_min) m_min = m_grp[k];
                  end
                  m_grp.delete();
                  m_hold = 1'b1;
               end
            end
            if (take) m_fifo.push_back(int'(in_d));
            else if (in_valid && m_cnt < 255) m_cnt++;
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         begin
            int exp_full, exp_drop;
            exp_full = (m_fifo.size() == DEPTH) ? 1 : 0;
            exp_drop = (rst_n && in_valid && exp_full == 1 &&
                        !(!m_hold && m_fifo.size() > 0)) ? 1 : 0;
            chk("out_valid", int'(o_valid), int'(m_hold));
            chk("out_sum",   int'(o_sum),   int'(m_sum));
            chk("out_max",   int'(o_max),   int'(m_max));
            chk("out_min",   int'(o_min),   int'(m_min));
            chk("full",      int'(o_full),  exp_full);
            chk("drop",      int'(o_drop),  exp_drop);
            chk("drop_cnt",  int'(o_drop_cnt), int'(m_cnt));
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic cyc(input bit v, input logic [7:0] d, input bit r);
      @(negedge clk);
      in_valid  = v;
      in_d      = d;
      out_ready = r;
   endtask

   // Idle with out_ready=1 until a record shows, then pin its literal values.
   task automatic wait_rec(input int s, input int mx, input int mn);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         cyc(1'b0, 8'd0, 1'b1);
         #3;
         if (o_valid) seen = 1'b1;
      end
      chk("record_seen", int'(seen), 1);
      if (seen) begin
         chk("rec_sum", int'(o_sum), s);
         chk("rec_max", int'(o_max), mx);
         chk("rec_min", int'(o_min), mn);
      end
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_d = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #3;
      chk("rst_out_valid", int'(o_valid), 0);
      chk("rst_out_sum",   int'(o_sum), 0);
      chk("rst_full",      int'(o_full), 0);
      chk("rst_drop_cnt",  int'(o_drop_cnt), 0);
      @(negedge clk) rst_n = 1'b1;

      // Spaced 10,20,30,40 with out_ready=1: record two cycles after 40.
      cyc(1'b1, 8'd10, 1'b1); cyc(1'b0, 8'd0, 1'b1); cyc(1'b0, 8'd0, 1'b1);
      cyc(1'b1, 8'd20, 1'b1); cyc(1'b0, 8'd0, 1'b1); cyc(1'b0, 8'd0, 1'b1);
      cyc(1'b1, 8'd30, 1'b1); cyc(1'b0, 8'd0, 1'b1); cyc(1'b0, 8'd0, 1'b1);
      cyc(1'b1, 8'd40, 1'b1); #3; chk("lat_c0_valid", int'(o_valid), 0);
      cyc(1'b0, 8'd0, 1'b1);  #3; chk("lat_c1_valid", int'(o_valid), 0);
      cyc(1'b0, 8'd0, 1'b1);  #3;
      chk("lat_c2_valid", int'(o_valid), 1);
      chk("g1_sum", int'(o_sum), 100);
      chk("g1_max", int'(o_max), 40);
      chk("g1_min", int'(o_min), 10);
      chk("g1_drop_cnt", int'(o_drop_cnt), 0);
      cyc(1'b0, 8'd0, 1'b1);  #3; chk("g1_one_cycle", int'(o_valid), 0);

      // All-255 group then a small group: accumulators must clear between.
      repeat (4) cyc(1'b1, 8'd255, 1'b1);
      wait_rec(1020, 255, 255);
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'(i), 1'b1);
      wait_rec(6, 3, 0);
      repeat (4) cyc(1'b0, 8'd0, 1'b1);

      // out_ready low, 1..12 back-to-back: 9..12 dropped.
      for (int i = 1; i <= 12; i++) begin
         cyc(1'b1, 8'(i), 1'b0);
         if (i >= 9) begin #3; chk("fill_drop", int'(o_drop), 1); end
      end
      cyc(1'b0, 8'd0, 1'b0); #3;
      chk("fill_full", int'(o_full), 1);
      chk("fill_drop_cnt", int'(o_drop_cnt), 4);
      chk("fill_hold_sum", int'(o_sum), 10);
      wait_rec(10, 4, 1);
      wait_rec(26, 8, 5);
      repeat (8) cyc(1'b0, 8'd0, 1'b1);
      #3; chk("fill_no_third", int'(o_valid), 0);

      // Full in HOLD: push on the acceptance cycle drops; next cycle push+pop.
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(50 + i), 1'b0);
      cyc(1'b1, 8'd99, 1'b1); #3;
      chk("hold_full_drop", int'(o_drop), 1);
      cyc(1'b1, 8'd77, 1'b1); #3;
      chk("acc_full_nodrop", int'(o_drop), 0);
      chk("acc_drop_cnt", int'(o_drop_cnt), 5);
      cyc(1'b0, 8'd0, 1'b1); #3;
      chk("acc_full_kept", int'(o_full), 1);
      wait_rec(222, 57, 54);

      // Randomised traffic: first with a mostly ready sink, then a slow one.
      repeat (1500) cyc(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                        $urandom_range(0, 3) != 0);
      repeat (1500) cyc($urandom_range(0, 2) != 0, 8'($urandom_range(0, 255)),
                        $urandom_range(0, 3) == 0);

      // Long overflow: drop counter saturates.
      repeat (320) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
      #3;
      chk("sat_drop_cnt", int'(o_drop_cnt), 255);
      chk("sat_drop_pulse", int'(o_drop), 1);

      // Clean reset, then asynchronous reset mid-group.
      @(negedge clk) begin rst_n = 1'b0; in_valid = 1'b0; end
      @(negedge clk) rst_n = 1'b1;
      cyc(1'b1, 8'd1, 1'b0); cyc(1'b1, 8'd2, 1'b0); cyc(1'b0, 8'd0, 1'b0);
      @(negedge clk); #3 rst_n = 1'b0; #1;
      chk("arst_grp_drop_cnt", int'(o_drop_cnt), 0);
      chk("arst_grp_valid", int'(o_valid), 0);
      @(negedge clk) rst_n = 1'b1;

      // Asynchronous reset while a record is held.
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'(100 + i), 1'b0);
      repeat (3) cyc(1'b0, 8'd0, 1'b0);
      #3; chk("pre_arst_valid", int'(o_valid), 1);
      @(negedge clk); #3 rst_n = 1'b0; #1;
      chk("arst_hold_valid", int'(o_valid), 0);
      chk("arst_hold_sum", int'(o_sum), 0);
      chk("arst_hold_max", int'(o_max), 0);
      chk("arst_hold_min", int'(o_min), 0);
      @(negedge clk) rst_n = 1'b1;
      for (int i = 5; i <= 8; i++) cyc(1'b1, 8'(i), 1'b1);
      wait_rec(26, 8, 5);
      repeat (4) cyc(1'b0, 8'd0, 1'b1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
